// File: rtl/av_slave_arbiter.sv
// av_slave_arbiter
// Two-master, one-slave Avalon-MM arbiter. Master 0 is the visor debug
// master, master 1 is the target CPU I/O master. Ownership is held by a
// three-state FSM (IDLE/OWN0/OWN1). Each grant covers exactly one transfer,
// and every transfer is followed by an IDLE cycle. A new request that
// appears in IDLE is granted on the next clock edge.
//
// Build option:
//   AV_ARB_ROUND_ROBIN_EN - when defined, contention is resolved in
//                           round-robin order using a last-owner register.
//                           When undefined, master 0 always wins contention.
module av_slave_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          sysclk,
    input  logic          sysreset,

    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_writedata,
    input  logic          m0_write,
    input  logic          m0_read,
    output logic          m0_waitrequest,
    output logic [DW-1:0] m0_readdata,

    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_writedata,
    input  logic          m1_write,
    input  logic          m1_read,
    output logic          m1_waitrequest,
    output logic [DW-1:0] m1_readdata,

    output logic [AW-1:0] s_address,
    output logic [DW-1:0] s_writedata,
    output logic          s_write,
    output logic          s_read,
    input  logic          s_waitrequest,
    input  logic [DW-1:0] s_readdata,

    output logic [1:0]    grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state;

    logic m0_req;
    logic m1_req;
    logic m0_wins;

    // A write together with a read still counts as a single request.
    assign m0_req = m0_write | m0_read;
    assign m1_req = m1_write | m1_read;

`ifdef AV_ARB_ROUND_ROBIN_EN
    // last_owner = 1 means m1 owned the slave most recently, so m0 wins the
    // next contention. It resets to 1 so m0 wins the first contention.
    logic last_owner;

    assign m0_wins = last_owner;

    // Record which master was granted on each IDLE -> OWN transition.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            last_owner <= 1'b1;
        end else if (state == IDLE) begin
            if (m0_req && (!m1_req || last_owner)) begin
                last_owner <= 1'b0;
            end else if (m1_req) begin
                last_owner <= 1'b1;
            end
        end
    end
`else
    // Fixed priority: the debug master always wins contention.
    assign m0_wins = 1'b1;
`endif

    // Ownership FSM. grant is registered together with the state, so it is
    // never 11 and it changes only on a clock edge or on reset.
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state <= IDLE;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req && (!m1_req || m0_wins)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                    end else if (m1_req) begin
                        state <= OWN1;
                        grant <= 2'b10;
                    end
                end
                OWN0: begin
                    // The transfer completes, or the owner drops its command.
                    if (!m0_req || !s_waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                OWN1: begin
                    if (!m1_req || !s_waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Route the owner's command to the slave and the slave response back to
    // the owner. The other master sees waitrequest high and zero readdata.
    always_comb begin
        s_address      = '0;
        s_writedata    = '0;
        s_write        = 1'b0;
        s_read         = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = '0;
        m1_readdata    = '0;
        case (state)
            OWN0: begin
                s_address      = m0_address;
                s_writedata    = m0_writedata;
                s_write        = m0_write;
                s_read         = m0_read;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
            end
            OWN1: begin
                s_address      = m1_address;
                s_writedata    = m1_writedata;
                s_write        = m1_write;
                s_read         = m1_read;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_av_slave_arbiter.sv
// tb_av_slave_arbiter
// Table-driven bench for av_slave_arbiter. Each record holds one cycle of
// stimulus and the outputs expected in that cycle. Expected records enter a
// scoreboard queue when they are driven and are popped when the outputs are
// sampled. The contention expectations follow AV_ARB_ROUND_ROBIN_EN.
module tb_av_slave_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
`ifdef AV_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic          sysclk;
    logic          sysreset;
    logic [AW-1:0] m0_address;
    logic [DW-1:0] m0_writedata;
    logic          m0_write;
    logic          m0_read;
    logic          m0_waitrequest;
    logic [DW-1:0] m0_readdata;
    logic [AW-1:0] m1_address;
    logic [DW-1:0] m1_writedata;
    logic          m1_write;
    logic          m1_read;
    logic          m1_waitrequest;
    logic [DW-1:0] m1_readdata;
    logic [AW-1:0] s_address;
    logic [DW-1:0] s_writedata;
    logic          s_write;
    logic          s_read;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic [1:0]    grant;

    av_slave_arbiter #(.AW(AW), .DW(DW)) dut (
        .sysclk         (sysclk),
        .sysreset       (sysreset),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_write       (m0_write),
        .m0_read        (m0_read),
        .m0_waitrequest (m0_waitrequest),
        .m0_readdata    (m0_readdata),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_write       (m1_write),
        .m1_read        (m1_read),
        .m1_waitrequest (m1_waitrequest),
        .m1_readdata    (m1_readdata),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_write        (s_write),
        .s_read         (s_read),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .grant          (grant)
    );

    // One cycle of stimulus and the outputs expected in that cycle.
    // cmd = {m0_write, m0_read, m1_write, m1_read}, swsr = {s_write, s_read},
    // waits = {m0_waitrequest, m1_waitrequest}.
    typedef struct {
        logic [3:0]  cmd;
        logic [15:0] a0, d0, a1, d1;
        logic        sw;
        logic [15:0] srd;
        logic [1:0]  g;
        logic [1:0]  swsr;
        logic [15:0] sa, sd;
        logic [1:0]  waits;
        logic [15:0] r0, r1;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl_basic[$];
    vec_t tbl_contend[$];
    vec_t tbl_wait[$];
    vec_t tbl_own1[$];
    vec_t tbl_after_rst[$];
    vec_t tbl_drop[$];
    vec_t tbl_wr_rd[$];

    int checks = 0;
    int errors = 0;
    int vec_no = 0;

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] cmd,
                                input logic [15:0] a0, input logic [15:0] d0,
                                input logic [15:0] a1, input logic [15:0] d1,
                                input logic sw, input logic [15:0] srd,
                                input logic [1:0] g, input logic [1:0] swsr,
                                input logic [15:0] sa, input logic [15:0] sd,
                                input logic [1:0] waits,
                                input logic [15:0] r0, input logic [15:0] r1);
        vec_t v;
        v.cmd = cmd; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.sw = sw; v.srd = srd; v.g = g; v.swsr = swsr; v.sa = sa; v.sd = sd;
        v.waits = waits; v.r0 = r0; v.r1 = r1;
        return v;
    endfunction

    task automatic check_value(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one record on the falling edge and queue its expectations.
    task automatic apply_stimulus(input vec_t v);
        @(negedge sysclk);
        {m0_write, m0_read, m1_write, m1_read} = v.cmd;
        m0_address    = v.a0;
        m0_writedata  = v.d0;
        m1_address    = v.a1;
        m1_writedata  = v.d1;
        s_waitrequest = v.sw;
        s_readdata    = v.srd;
        exp_q.push_back(v);
    endtask

    // Sample the outputs shortly after driving and compare with the oldest expectation.
    task automatic check_output();
        vec_t e;
        #1;
        vec_no++;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue expected entry", vec_no);
            return;
        end
        checks--;
        e = exp_q.pop_front();
        check_value($sformatf("vec%0d grant", vec_no), {14'd0, grant}, {14'd0, e.g});
        check_value($sformatf("vec%0d s_write", vec_no), {15'd0, s_write}, {15'd0, e.swsr[1]});
        check_value($sformatf("vec%0d s_read", vec_no), {15'd0, s_read}, {15'd0, e.swsr[0]});
        check_value($sformatf("vec%0d s_address", vec_no), s_address, e.sa);
        check_value($sformatf("vec%0d s_writedata", vec_no), s_writedata, e.sd);
        check_value($sformatf("vec%0d m0_waitrequest", vec_no), {15'd0, m0_waitrequest}, {15'd0, e.waits[1]});
        check_value($sformatf("vec%0d m1_waitrequest", vec_no), {15'd0, m1_waitrequest}, {15'd0, e.waits[0]});
        check_value($sformatf("vec%0d m0_readdata", vec_no), m0_readdata, e.r0);
        check_value($sformatf("vec%0d m1_readdata", vec_no), m1_readdata, e.r1);
    endtask

    task automatic run_vec(input vec_t v);
        apply_stimulus(v);
        check_output();
    endtask

    // Outputs must show the reset values without any clock edge.
    task automatic check_reset_outputs(input string tag);
        check_value({tag, " grant"}, {14'd0, grant}, 16'h0000);
        check_value({tag, " s_write"}, {15'd0, s_write}, 16'h0000);
        check_value({tag, " s_read"}, {15'd0, s_read}, 16'h0000);
        check_value({tag, " s_address"}, s_address, 16'h0000);
        check_value({tag, " m0_waitrequest"}, {15'd0, m0_waitrequest}, 16'h0001);
        check_value({tag, " m1_waitrequest"}, {15'd0, m1_waitrequest}, 16'h0001);
        check_value({tag, " m0_readdata"}, m0_readdata, 16'h0000);
        check_value({tag, " m1_readdata"}, m1_readdata, 16'h0000);
    endtask

    task automatic reset_dut();
        @(negedge sysclk);
        sysreset = 1'b1;
        {m0_write, m0_read, m1_write, m1_read} = 4'b0000;
        m0_address = '0; m0_writedata = '0; m1_address = '0; m1_writedata = '0;
        s_waitrequest = 1'b0; s_readdata = '0;
        @(negedge sysclk);
        sysreset = 1'b0;
    endtask

    initial begin
        bit owner_m1;

        // Single m1 write: arbitration cycle, one transfer, then IDLE.
        tbl_basic.push_back(mk(4'b0010, 16'h0, 16'h0, 16'h0010, 16'hBEEF, 1'b0, 16'h5A5A,
                               2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));
        tbl_basic.push_back(mk(4'b0010, 16'h0, 16'h0, 16'h0010, 16'hBEEF, 1'b0, 16'h5A5A,
                               2'b10, 2'b10, 16'h0010, 16'hBEEF, 2'b10, 16'h0, 16'h5A5A));
        tbl_basic.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h5A5A,
                               2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));

        // Both masters write continuously with a ready slave: four transfers.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                tbl_contend.push_back(mk(4'b1010, 16'h0100, 16'h1111, 16'h0200, 16'h2222, 1'b0, 16'h0F0F,
                                         2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));
            end else begin
                owner_m1 = RR_EN && ((k / 2) % 2 == 1);
                if (owner_m1)
                    tbl_contend.push_back(mk(4'b1010, 16'h0100, 16'h1111, 16'h0200, 16'h2222, 1'b0, 16'h0F0F,
                                             2'b10, 2'b10, 16'h0200, 16'h2222, 2'b10, 16'h0, 16'h0F0F));
                else
                    tbl_contend.push_back(mk(4'b1010, 16'h0100, 16'h1111, 16'h0200, 16'h2222, 1'b0, 16'h0F0F,
                                             2'b01, 2'b10, 16'h0100, 16'h1111, 2'b01, 16'h0F0F, 16'h0));
            end
        end
        tbl_contend.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0F0F,
                                 2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));

        // m0 read stalled for 5 cycles while m1 read waits and is ignored.
        tbl_wait.push_back(mk(4'b0101, 16'h0030, 16'h0, 16'h0040, 16'h0, 1'b1, 16'h0,
                              2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));
        for (int k = 0; k < 5; k++)
            tbl_wait.push_back(mk(4'b0101, 16'h0030, 16'h0, 16'h0040, 16'h0, 1'b1, 16'h0,
                                  2'b01, 2'b01, 16'h0030, 16'h0, 2'b11, 16'h0, 16'h0));
        tbl_wait.push_back(mk(4'b0101, 16'h0030, 16'h0, 16'h0040, 16'h0, 1'b0, 16'h1234,
                              2'b01, 2'b01, 16'h0030, 16'h0, 2'b01, 16'h1234, 16'h0));
        tbl_wait.push_back(mk(4'b0000, 16'h0030, 16'h0, 16'h0040, 16'h0, 1'b0, 16'h1234,
                              2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));

        // m1 write stalled; reset is pulsed mid-OWN1 and the request held.
        tbl_own1.push_back(mk(4'b0010, 16'h0, 16'h0, 16'h0050, 16'h7777, 1'b1, 16'h0,
                              2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));
        tbl_own1.push_back(mk(4'b0010, 16'h0, 16'h0, 16'h0050, 16'h7777, 1'b1, 16'h0,
                              2'b10, 2'b10, 16'h0050, 16'h7777, 2'b11, 16'h0, 16'h0));
        tbl_after_rst.push_back(mk(4'b0010, 16'h0, 16'h0, 16'h0050, 16'h7777, 1'b1, 16'h0,
                                   2'b10, 2'b10, 16'h0050, 16'h7777, 2'b11, 16'h0, 16'h0));
        tbl_after_rst.push_back(mk(4'b0010, 16'h0, 16'h0, 16'h0050, 16'h7777, 1'b0, 16'hAAAA,
                                   2'b10, 2'b10, 16'h0050, 16'h7777, 2'b10, 16'h0, 16'hAAAA));
        tbl_after_rst.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0050, 16'h7777, 1'b0, 16'hAAAA,
                                   2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));

        // m0 drops its write while stalled: IDLE next cycle, nothing forwarded.
        tbl_drop.push_back(mk(4'b1000, 16'h0060, 16'h9999, 16'h0, 16'h0, 1'b1, 16'h0,
                              2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));
        tbl_drop.push_back(mk(4'b1000, 16'h0060, 16'h9999, 16'h0, 16'h0, 1'b1, 16'h0,
                              2'b01, 2'b10, 16'h0060, 16'h9999, 2'b11, 16'h0, 16'h0));
        tbl_drop.push_back(mk(4'b0000, 16'h0060, 16'h9999, 16'h0, 16'h0, 1'b1, 16'h0,
                              2'b01, 2'b00, 16'h0060, 16'h9999, 2'b11, 16'h0, 16'h0));
        tbl_drop.push_back(mk(4'b0000, 16'h0060, 16'h9999, 16'h0, 16'h0, 1'b1, 16'h0,
                              2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));

        // m1 write-plus-read is forwarded unchanged.
        tbl_wr_rd.push_back(mk(4'b0011, 16'h0, 16'h0, 16'h0070, 16'hABCD, 1'b0, 16'h4321,
                               2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));
        tbl_wr_rd.push_back(mk(4'b0011, 16'h0, 16'h0, 16'h0070, 16'hABCD, 1'b0, 16'h4321,
                               2'b10, 2'b11, 16'h0070, 16'hABCD, 2'b10, 16'h0, 16'h4321));
        tbl_wr_rd.push_back(mk(4'b0000, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 16'h4321,
                               2'b00, 2'b00, 16'h0, 16'h0, 2'b11, 16'h0, 16'h0));

        $display("[TB] starting av_slave_arbiter bench (round robin = %0d)", RR_EN);
        sysreset = 1'b0;
        {m0_write, m0_read, m1_write, m1_read} = 4'b0000;
        m0_address = '0; m0_writedata = '0; m1_address = '0; m1_writedata = '0;
        s_waitrequest = 1'b0; s_readdata = '0;
        #1 sysreset = 1'b1;
        #1 check_reset_outputs("power-on reset");
        @(negedge sysclk);
        sysreset = 1'b0;

        foreach (tbl_basic[i]) run_vec(tbl_basic[i]);

        reset_dut();
        foreach (tbl_contend[i]) run_vec(tbl_contend[i]);

        reset_dut();
        foreach (tbl_wait[i]) run_vec(tbl_wait[i]);

        reset_dut();
        foreach (tbl_own1[i]) run_vec(tbl_own1[i]);
        #1 sysreset = 1'b1;
        #1 check_reset_outputs("mid-OWN1 reset");
        #1 sysreset = 1'b0;
        foreach (tbl_after_rst[i]) run_vec(tbl_after_rst[i]);

        reset_dut();
        foreach (tbl_drop[i]) run_vec(tbl_drop[i]);

        foreach (tbl_wr_rd[i]) run_vec(tbl_wr_rd[i]);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/av_slave_arbiter.md
AV_SLAVE_ARBITER -- requirements
Module: av_slave_arbiter

Interface
REQ-001 Parameter AW, default 16: address width of all ports.
REQ-002 Parameter DW, default 16: data width of all ports.
REQ-003 sysclk  input  1  sole clock; all state changes on its rising edge.
REQ-004 sysreset  input  1  asynchronous, active-high reset.
REQ-005 m0_address/m0_writedata/m0_write/m0_read  input  AW/DW/1/1  master 0 (visor debug Avalon master) command.
REQ-006 m0_waitrequest  output 1; m0_readdata  output DW  master 0 response.
REQ-007 m1_address/m1_writedata/m1_write/m1_read  input  AW/DW/1/1  master 1 (target CPU I/O master) command.
REQ-008 m1_waitrequest  output 1; m1_readdata  output DW  master 1 response.
REQ-009 s_address/s_writedata/s_write/s_read  output  AW/DW/1/1  shared downstream slave command.
REQ-010 s_waitrequest  input 1; s_readdata  input DW  shared slave response.
REQ-011 grant  output 2  one-hot current owner (bit0 = m0, bit1 = m1), 00 when idle.

Function
REQ-012 A master requests when its write or read is 1; both asserted together is a write-plus-read and is forwarded unchanged.
REQ-013 States IDLE, OWN0, OWN1; state is registered.
REQ-014 IDLE: no request -> stay; one requester -> OWN of that master; both -> winner per REQ-026/027.
REQ-015 Arbitration latency is exactly one cycle: the slave sees no command in the cycle a request first appears in IDLE.
REQ-016 In OWNn, s_address/s_writedata/s_write/s_read equal master n's inputs combinationally; the other master's inputs are ignored.
REQ-017 In OWNn, mn_waitrequest = s_waitrequest and mn_readdata = s_readdata.
REQ-018 The non-owning master always sees waitrequest = 1; in IDLE both see waitrequest = 1.
REQ-019 m0_readdata and m1_readdata are 0 when their master does not own the slave.
REQ-020 A transfer completes in the cycle where the owner's command is asserted and s_waitrequest = 0; the next state is IDLE.
REQ-021 Back-to-back requests from the same master therefore cost one IDLE cycle between transfers.
REQ-022 If the owner drops both write and read before completion (protocol violation), the next state is IDLE and no completion is recorded.
REQ-023 In IDLE, s_write = s_read = 0 and s_address = s_writedata = 0.
REQ-024 grant is driven from the state register and is never 11.
REQ-025 s_waitrequest held 1 indefinitely keeps the owner granted; there is no timeout.

Configuration
REQ-026 With AV_ARB_ROUND_ROBIN_EN defined, a registered last-owner bit selects the winner: on contention the master that did not own most recently wins; the bit resets to 1 so m0 wins the first contention.
REQ-027 Without AV_ARB_ROUND_ROBIN_EN, m0 (debug) always wins contention; the last-owner register is not instantiated.

Reset
REQ-028 Asserting sysreset immediately forces IDLE, grant = 00, s_write = s_read = 0, both waitrequests = 1, readdata = 0, and, under REQ-026, last-owner = 1.
REQ-029 A transfer interrupted by reset is abandoned; after deassertion an active request re-arbitrates after one cycle per REQ-015.

Verification
REQ-030 Bench: reset, then m1_write with address 0x0010 and data 0xBEEF, s_waitrequest = 0 -> cycle 1 grant = 00; cycle 2 s_write = 1, s_address = 0x0010, m1_waitrequest = 0, grant = 10; cycle 3 IDLE.
REQ-031 Bench: m0 and m1 write in the same cycle, macro off, slave always ready, both held for 4 transfers -> all 4 grants go to m0 and m1_waitrequest stays 1.
REQ-032 Bench: same stimulus, AV_ARB_ROUND_ROBIN_EN on -> grant sequence 01,10,01,10.
REQ-033 Bench: m0_read with s_waitrequest = 1 for 5 cycles and s_readdata = 0x1234 on release -> m0_waitrequest = 1 for those 5 cycles, then 0 with m0_readdata = 0x1234; m1_waitrequest = 1 throughout.
REQ-034 Bench: sysreset pulsed mid-OWN1 while s_waitrequest = 1 -> outputs reach REQ-028 values without a clock edge; a held m1 request regains grant 10 one cycle after release.
REQ-035 Bench: m0 drops write while s_waitrequest = 1 in OWN0 -> next cycle IDLE, grant = 00, s_write = 0.
